// File: rtl/store_pkg.sv
// store_pkg: shared size encodings, FSM states and timeout default for the store unit
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: byte enables and lane-aligned data for both beats of a store
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic        two_beat
);

    logic [3:0]  mask;
    logic [31:0] dmask;
    logic [7:0]  m8;
    logic [63:0] d64;

    // shift the size mask and masked data across an 8-lane window spanning two words
    always_comb begin
        mask     = size == SZ_BYTE ? 4'b0001 :
                   size == SZ_HALF ? 4'b0011 :
                   size == SZ_WORD ? 4'b1111 : 4'b0000;
        dmask    = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        m8       = {4'b0000, mask} << offset;
        d64      = {32'b0, data & dmask} << {offset, 3'b000};
        be0      = m8[3:0];
        be1      = m8[7:4];
        wdata0   = d64[31:0];
        wdata1   = d64[63:32];
        two_beat = |m8[7:4];
    end

endmodule

// File: rtl/store_unit.sv
// store_unit: splits stores into word-aligned beats and drives the data-memory handshake
module store_unit
    import store_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        store_valid,
    output logic        store_ready,
    input  logic [1:0]  store_size,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    output logic        store_done,
    output logic        store_fault,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state, state_n;
    logic [CW-1:0] cnt;
    logic        accept, expired, fault_n;
    logic        two_q;
    logic [3:0]  be1_q;
    logic [31:0] wdata1_q;
    logic [3:0]  l_be0, l_be1;
    logic [31:0] l_wdata0, l_wdata1;
    logic        l_two;

    store_lane_align u_align (
        .size     (store_size),
        .offset   (store_addr[1:0]),
        .data     (store_data),
        .be0      (l_be0),
        .be1      (l_be1),
        .wdata0   (l_wdata0),
        .wdata1   (l_wdata1),
        .two_beat (l_two)
    );

    // next state and fault decision; an ack in the last allowed cycle beats the timeout
    always_comb begin
        state_n = state;
        fault_n = 1'b0;
        accept  = store_valid & store_ready;
        expired = !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
        case (state)
            IDLE: begin
                if (accept && store_size == SZ_RSVD) fault_n = 1'b1;
                else if (accept) state_n = BEAT0;
            end
            BEAT0: begin
                if (mem_ack) state_n = two_q ? BEAT1 : DONE;
                else if (expired) begin
                    state_n = IDLE;
                    fault_n = 1'b1;
                end
            end
            BEAT1: begin
                if (mem_ack) state_n = DONE;
                else if (expired) begin
                    state_n = IDLE;
                    fault_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end

    // per-beat wait counter, restarted whenever the state changes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (state_n != state) cnt <= '0;
        else if (mem_req && !mem_ack) cnt <= cnt + 1'b1;
    end

    // registered outputs; beat 1 lanes are captured at accept and swapped in after beat 0 acks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store_ready <= 1'b1;
            mem_req     <= 1'b0;
            store_done  <= 1'b0;
            store_fault <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            two_q       <= 1'b0;
            be1_q       <= '0;
            wdata1_q    <= '0;
        end else begin
            store_ready <= state_n == IDLE;
            mem_req     <= state_n == BEAT0 || state_n == BEAT1;
            store_done  <= state_n == DONE;
            store_fault <= fault_n;
            if (state == IDLE && state_n == BEAT0) begin
                mem_addr  <= {store_addr[31:2], 2'b00};
                mem_be    <= l_be0;
                mem_wdata <= l_wdata0;
                two_q     <= l_two;
                be1_q     <= l_be1;
                wdata1_q  <= l_wdata1;
            end else if (state == BEAT0 && state_n == BEAT1) begin
                mem_addr  <= mem_addr + 32'd4;
                mem_be    <= be1_q;
                mem_wdata <= wdata1_q;
            end
        end
    end

endmodule
